spi_master_burst: RTL and testbench



---
 rtl/spi_master_burst.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_spi_master_burst.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_burst.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_burst
// Purpose  : Burst-capable SPI master with runtime CPOL/CPHA, bit order and
//            word length, one-hot chip selects and a valid/ready TX stream.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_burst #(
    parameter int DATA_WIDTH        = 16,
    parameter int NUM_CS            = 4,
    parameter int CLK_DIVIDER_WIDTH = 8,
    parameter int BURST_WIDTH       = 8,
    localparam int WL_W             = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
    localparam int CS_W             = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         cpol,
    input  logic                         cpha,
    input  logic                         lsb_first,
    input  logic [CLK_DIVIDER_WIDTH-1:0] clk_div,
    input  logic [WL_W-1:0]              word_len,
    input  logic [BURST_WIDTH-1:0]       burst_len,
    input  logic [CS_W-1:0]              cs_sel,
    input  logic [DATA_WIDTH-1:0]        tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [DATA_WIDTH-1:0]        rx_data,
    output logic                         rx_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         sclk,
    output logic                         mosi,
    input  logic                         miso,
    output logic [NUM_CS-1:0]            csb
);

    localparam int EC_W = WL_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LEAD  = 3'd2,
        SHIFT = 3'd3,
        TRAIL = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic                         cpol_q, cpol_d;
    logic                         cpha_q, cpha_d;
    logic                         lsb_q, lsb_d;
    logic [CLK_DIVIDER_WIDTH-1:0] div_q, div_d;
    logic [WL_W-1:0]              wlen_q, wlen_d;
    logic [BURST_WIDTH-1:0]       burst_q, burst_d;
    logic [CS_W-1:0]              cs_q, cs_d;
    logic                         first_q, first_d;
    logic [CLK_DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
    logic [EC_W-1:0]              edge_cnt_q, edge_cnt_d;
    logic [DATA_WIDTH-1:0]        tx_word_q, tx_word_d;
    logic [DATA_WIDTH-1:0]        rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]        rx_data_q, rx_data_d;
    logic                         rx_valid_q, rx_valid_d;
    logic                         sclk_q, sclk_d;
    logic                         mosi_q, mosi_d;
    logic [NUM_CS-1:0]            csb_q, csb_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    // Edge bookkeeping: edge_cnt_q counts SCLK edges already issued in this
    // word, so the edge about to happen is number edge_cnt_q+1 and belongs to
    // bit edge_cnt_q/2. Even count means the next edge is a leading edge.
    logic [WL_W-1:0]       w_bit_k;
    logic                  w_lead_edge;
    logic                  w_last_edge;
    logic                  w_capture;
    logic                  w_drive;
    logic [WL_W-1:0]       w_drive_k;
    logic [WL_W-1:0]       w_cap_idx;
    logic [WL_W-1:0]       w_drv_idx;
    logic [WL_W-1:0]       w_wlen_in;
    logic                  w_half_done;
    logic [NUM_CS-1:0]     w_csb_sel;
    logic [DATA_WIDTH-1:0] w_rx_upd;

    assign w_bit_k     = edge_cnt_q[EC_W-1:1];
    assign w_lead_edge = ~edge_cnt_q[0];
    assign w_last_edge = (edge_cnt_q == {wlen_q, 1'b1});
    assign w_capture   = cpha_q ? ~w_lead_edge : w_lead_edge;
    // With cpha=0 the trailing edge of the final bit has no next bit to drive.
    assign w_drive     = (cpha_q ? w_lead_edge : ~w_lead_edge) & ~w_last_edge;
    assign w_drive_k   = cpha_q ? w_bit_k : w_bit_k + 1'b1;
    assign w_cap_idx   = lsb_q ? w_bit_k : wlen_q - w_bit_k;
    assign w_drv_idx   = lsb_q ? w_drive_k : wlen_q - w_drive_k;
    assign w_half_done = (cnt_q == div_q);
    assign w_wlen_in   = (int'(word_len) > DATA_WIDTH - 1) ? WL_W'(DATA_WIDTH - 1) : word_len;

    // Active-low one-hot select; an out-of-range index selects nobody.
    always_comb begin
        w_csb_sel = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_q == CS_W'(i)) begin
                w_csb_sel[i] = 1'b0;
            end
        end
    end

    // Receive word with this edge's miso sample merged in, when it is a capture edge.
    always_comb begin
        w_rx_upd = rx_sh_q;
        if (w_capture) begin
            w_rx_upd[w_cap_idx] = miso;
        end
    end

    // Next-state and output decode for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        div_d      = div_q;
        wlen_d     = wlen_q;
        burst_d    = burst_q;
        cs_d       = cs_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_word_d  = tx_word_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        csb_d      = csb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                csb_d  = '1;
                busy_d = 1'b0;
                if (start) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    div_d   = clk_div;
                    wlen_d  = w_wlen_in;
                    burst_d = burst_len;
                    cs_d    = cs_sel;
                    first_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sclk_d = cpol_q;
                if (tx_valid) begin
                    tx_word_d  = tx_data;
                    rx_sh_d    = '0;
                    cnt_d      = '0;
                    edge_cnt_d = '0;
                    mosi_d     = lsb_q ? tx_data[0] : tx_data[wlen_q];
                    if (first_q) begin
                        csb_d   = w_csb_sel;
                        first_d = 1'b0;
                        state_d = LEAD;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            LEAD: begin
                sclk_d = cpol_q;
                if (w_half_done) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (w_half_done) begin
                    cnt_d      = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    rx_sh_d    = w_rx_upd;
                    if (w_drive) begin
                        mosi_d = tx_word_q[w_drv_idx];
                    end
                    if (w_last_edge) begin
                        rx_data_d  = w_rx_upd;
                        rx_valid_d = 1'b1;
                        if (burst_q != '0) begin
                            burst_d = burst_q - 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = TRAIL;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRAIL: begin
                sclk_d = cpol_q;
                if (w_half_done) begin
                    cnt_d   = '0;
                    csb_d   = '1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            wlen_q     <= '0;
            burst_q    <= '0;
            cs_q       <= '0;
            first_q    <= 1'b0;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            tx_word_q  <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csb_q      <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            div_q      <= div_d;
            wlen_q     <= wlen_d;
            burst_q    <= burst_d;
            cs_q       <= cs_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_word_q  <= tx_word_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            csb_q      <= csb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = (state_q == LOAD);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign csb      = csb_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_burst
// Purpose  : Directed self-checking bench for spi_master_burst (loopback).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_burst;

    logic        clk = 1'b0;
    logic        reset, start, start2, cpol, cpha, lsb_first, tx_valid;
    logic [7:0]  clk_div, burst_len;
    logic [3:0]  word_len;
    logic [1:0]  cs_sel;
    logic [15:0] tx_data;

    logic        tx_ready, rx_valid, busy, done, sclk, mosi, miso;
    logic [15:0] rx_data;
    logic [3:0]  csb;

    logic        tx_ready2, rx_valid2, busy2, done2, sclk2, mosi2, miso2;
    logic [15:0] rx_data2;
    logic [2:0]  csb2;

    assign miso  = mosi;
    assign miso2 = mosi2;

    always #5 clk = ~clk;

    spi_master_burst dut (
        .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .word_len(word_len),
        .burst_len(burst_len), .cs_sel(cs_sel), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .done(done), .sclk(sclk),
        .mosi(mosi), .miso(miso), .csb(csb)
    );

    // Three chip selects, so index 3 is out of range.
    spi_master_burst #(.NUM_CS(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .word_len(word_len),
        .burst_len(burst_len), .cs_sel(cs_sel), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .busy(busy2), .done(done2), .sclk(sclk2),
        .mosi(mosi2), .miso(miso2), .csb(csb2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clk edge.
    int          cyc = 0, edge_cnt = 0, rx_cnt = 0, done_cnt = 0;
    int          csb_rise = 0, csb_edge_err = 0;
    int          rx2_cnt = 0, done2_cnt = 0, csb2_low = 0;
    int          edge_log [0:511];
    logic [15:0] rx_log [0:31];
    logic [15:0] rx2_last = '0;
    logic [63:0] mosi_hist = '0;
    logic        sclk_prev = 1'b0;
    logic [3:0]  csb_prev = 4'hF;
    logic [3:0]  csb_exp = 4'hF;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        sclk_prev <= sclk;
        csb_prev  <= csb;
        if (busy && sclk != sclk_prev) begin
            edge_cnt <= edge_cnt + 1;
            if (edge_cnt < 512) edge_log[edge_cnt] <= cyc;
            if (csb != csb_exp) csb_edge_err <= csb_edge_err + 1;
            if ((sclk != cpol) ^ cpha) mosi_hist <= {mosi_hist[62:0], mosi};
        end
        if (rx_valid) begin
            if (rx_cnt < 32) rx_log[rx_cnt] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (csb_prev != 4'hF && csb == 4'hF) csb_rise <= csb_rise + 1;
        if (rx_valid2) begin
            rx2_cnt  <= rx2_cnt + 1;
            rx2_last <= rx_data2;
        end
        if (done2) done2_cnt <= done2_cnt + 1;
        if (csb2 != 3'b111) csb2_low <= csb2_low + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                       input logic [7:0] p_div, input logic [3:0] p_wl,
                       input logic [7:0] p_bl, input logic [1:0] p_cs);
        cpol = p_cpol; cpha = p_cpha; lsb_first = p_lsb;
        clk_div = p_div; word_len = p_wl; burst_len = p_bl; cs_sel = p_cs;
        tick();
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        tick();
        tx_valid = 1'b0;
        check("tx_handshake", 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(n < 5000), 32'd1);
    endtask

    int e0, r0, d0, c0, k0, n, stall_err;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; tx_valid = 1'b0; tx_data = '0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = '0; word_len = '0; burst_len = '0; cs_sel = '0;
        repeat (3) tick();

        // Reset values
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_csb", 32'(csb), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        tick();

        // 1: mode 0, 8-bit, cs 2, 0xA5
        cfg(1'b0, 1'b0, 1'b0, 8'd1, 4'd7, 8'd0, 2'd2);
        csb_exp = 4'b1011;
        e0 = edge_cnt; r0 = rx_cnt; d0 = done_cnt; c0 = csb_rise; k0 = csb_edge_err;
        check("t1_busy_pre", 32'(busy), 32'd0);
        pulse_start();
        check("t1_busy_post", 32'(busy), 32'd1);
        send_word(16'h00A5);
        wait_done("t1");
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_csb_end", 32'(csb), 32'hF);
        tick(); tick();
        check("t1_edges", 32'(edge_cnt - e0), 32'd16);
        check("t1_period", 32'(edge_log[e0+2] - edge_log[e0]), 32'd4);
        check("t1_span", 32'(edge_log[e0+15] - edge_log[e0]), 32'd30);
        check("t1_mosi", 32'(mosi_hist[7:0]), 32'hA5);
        check("t1_rx_cnt", 32'(rx_cnt - r0), 32'd1);
        check("t1_rx_data", 32'(rx_log[r0]), 32'h00A5);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_csb_edges", 32'(csb_edge_err - k0), 32'd0);
        check("t1_csb_rise", 32'(csb_rise - c0), 32'd1);

        // 2: mode 3, 16-bit, burst of 3, clk_div 0
        cfg(1'b1, 1'b1, 1'b0, 8'd0, 4'd15, 8'd2, 2'd0);
        csb_exp = 4'b1110;
        e0 = edge_cnt; r0 = rx_cnt; d0 = done_cnt; c0 = csb_rise; k0 = csb_edge_err;
        pulse_start();
        send_word(16'h1234);
        send_word(16'hBEEF);
        send_word(16'h0F0F);
        wait_done("t2");
        tick(); tick();
        check("t2_edges", 32'(edge_cnt - e0), 32'd96);
        check("t2_rx_cnt", 32'(rx_cnt - r0), 32'd3);
        check("t2_rx0", 32'(rx_log[r0]), 32'h1234);
        check("t2_rx1", 32'(rx_log[r0+1]), 32'hBEEF);
        check("t2_rx2", 32'(rx_log[r0+2]), 32'h0F0F);
        check("t2_mosi", mosi_hist[47:16], 32'h1234BEEF);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t2_csb_rise", 32'(csb_rise - c0), 32'd1);
        check("t2_csb_edges", 32'(csb_edge_err - k0), 32'd0);

        // 3: lsb-first, 4-bit word, upper tx bits must be masked off
        cfg(1'b0, 1'b0, 1'b1, 8'd2, 4'd3, 8'd0, 2'd1);
        csb_exp = 4'b1101;
        e0 = edge_cnt; r0 = rx_cnt;
        pulse_start();
        send_word(16'hFFF6);
        wait_done("t3");
        tick(); tick();
        check("t3_edges", 32'(edge_cnt - e0), 32'd8);
        check("t3_mosi", 32'(mosi_hist[3:0]), 32'h6);
        check("t3_rx_data", 32'(rx_log[r0]), 32'h0006);

        // 4: mode 2, burst of 2 with a 20-cycle underflow before word 2
        cfg(1'b1, 1'b0, 1'b0, 8'd1, 4'd7, 8'd1, 2'd0);
        csb_exp = 4'b1110;
        e0 = edge_cnt; r0 = rx_cnt; d0 = done_cnt;
        pulse_start();
        send_word(16'h003C);
        n = 0;
        while (rx_cnt == r0 && n < 5000) begin
            tick();
            n++;
        end
        check("t4_word1_seen", 32'(n < 5000), 32'd1);
        k0 = edge_cnt;
        stall_err = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_ready !== 1'b1 || csb !== 4'b1110 || sclk !== 1'b1 || busy !== 1'b1)
                stall_err++;
            tick();
        end
        check("t4_stall_state", 32'(stall_err), 32'd0);
        check("t4_stall_edges", 32'(edge_cnt - k0), 32'd0);
        send_word(16'h00C3);
        wait_done("t4");
        tick(); tick();
        check("t4_edges", 32'(edge_cnt - e0), 32'd32);
        check("t4_rx0", 32'(rx_log[r0]), 32'h003C);
        check("t4_rx1", 32'(rx_log[r0+1]), 32'h00C3);
        check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 5: reset during the first word, then a clean transfer
        cfg(1'b0, 1'b0, 1'b0, 8'd3, 4'd15, 8'd0, 2'd3);
        csb_exp = 4'b0111;
        e0 = edge_cnt; r0 = rx_cnt; d0 = done_cnt;
        pulse_start();
        send_word(16'hFFFF);
        n = 0;
        while (edge_cnt < e0 + 5 && n < 5000) begin
            tick();
            n++;
        end
        check("t5_edges_seen", 32'(n < 5000), 32'd1);
        reset = 1'b1;
        tick();
        check("t5_rst_csb", 32'(csb), 32'hF);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_sclk", 32'(sclk), 32'd0);
        check("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
        reset = 1'b0;
        repeat (40) tick();
        check("t5_no_rx", 32'(rx_cnt - r0), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        cfg(1'b0, 1'b0, 1'b0, 8'd0, 4'd7, 8'd0, 2'd3);
        pulse_start();
        send_word(16'h005A);
        wait_done("t5b");
        tick(); tick();
        check("t5b_rx_data", 32'(rx_log[r0]), 32'h005A);
        check("t5b_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 6: start while busy is ignored and config stays latched
        cfg(1'b0, 1'b0, 1'b0, 8'd1, 4'd7, 8'd0, 2'd1);
        csb_exp = 4'b1101;
        e0 = edge_cnt; r0 = rx_cnt; d0 = done_cnt; k0 = csb_edge_err;
        pulse_start();
        send_word(16'h0081);
        word_len = 4'd3; cs_sel = 2'd2; clk_div = 8'd0; lsb_first = 1'b1;
        pulse_start();
        wait_done("t6");
        repeat (10) tick();
        check("t6_idle_after", 32'(busy), 32'd0);
        check("t6_edges", 32'(edge_cnt - e0), 32'd16);
        check("t6_rx_data", 32'(rx_log[r0]), 32'h0081);
        check("t6_mosi", 32'(mosi_hist[7:0]), 32'h81);
        check("t6_csb_edges", 32'(csb_edge_err - k0), 32'd0);
        check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 6b: cs_sel out of range on a 3-select instance
        cfg(1'b0, 1'b0, 1'b0, 8'd1, 4'd7, 8'd0, 2'd3);
        tx_data = 16'h0096;
        tx_valid = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        tx_valid = 1'b0;
        check("t6b_done_seen", 32'(n < 5000), 32'd1);
        tick(); tick();
        check("t6b_rx_cnt", 32'(rx2_cnt), 32'd1);
        check("t6b_rx_data", 32'(rx2_last), 32'h0096);
        check("t6b_done_cnt", 32'(done2_cnt), 32'd1);
        check("t6b_csb_low", 32'(csb2_low), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
